// File: rtl/prng_pkg.sv
// Shared types and the LFSR step function for the pattern generator.
package prng_pkg;

  typedef enum logic {IDLE, SKIP} fsm_e;

  localparam int MAX_W = 64;
  localparam logic [16:0] DEF_TAPS = 17'h00005;

  // Right-shift Fibonacci step; a zero state injects a one to escape lock-up.
  function automatic logic [MAX_W-1:0] lfsr_step(
    input logic [MAX_W-1:0] state,
    input logic [MAX_W-1:0] taps,
    input int               w
  );
    logic fb;
    fb = (^(state & taps)) ^ (state == '0);
    return (state >> 1) | ({{(MAX_W-1){1'b0}}, fb} << (w - 1));
  endfunction

endpackage

// File: rtl/prng_slot_bank.sv
// Save/restore register file: one write port, one async read port.
module prng_slot_bank
  import prng_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int DW = 17,
  parameter int SW = 2,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic [SW-1:0] ridx,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [SLOTS];
  logic [DW-1:0] mem_d [SLOTS];

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (we && widx == SW'(i)) mem_d[i] = wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (ridx == SW'(i)) rdata = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= RST_VAL;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/prng_vec_gen.sv
// Parametrised LFSR vector generator with slots and skip-ahead.
// Optional step counter output enabled by PRNG_STEP_CNT_EN.
module prng_vec_gen
  import prng_pkg::*;
#(
  parameter int LFSR_W = 17,
  parameter int OUT_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(DEF_TAPS),
  parameter int SLOTS = 4,
  parameter int CNT_W = 16,
  parameter logic [LFSR_W-1:0] RESET_SEED = '0,
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic              next,
  input  logic              save,
  input  logic              restore,
  input  logic [SW-1:0]     slot,
  input  logic              skip_start,
  input  logic [CNT_W-1:0]  skip_cnt,
`ifdef PRNG_STEP_CNT_EN
  output logic [31:0]       step_cnt,
`endif
  output logic              busy,
  output logic [OUT_W-1:0]  out
);

`ifdef PRNG_STEP_CNT_EN
  localparam int SCW = 32;
`else
  localparam int SCW = 0;
`endif
  localparam int DW = LFSR_W + SCW;

  logic [LFSR_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  fsm_e              fsm_q, fsm_d;
  logic              busy_q, busy_d;
  logic [MAX_W-1:0]  step_full;
  logic [LFSR_W-1:0] stepped;
  logic              slot_ok;
  logic              do_rest;
  logic [DW-1:0]     wdata, rdata;

`ifdef PRNG_STEP_CNT_EN
  logic [31:0] sc_q, sc_d;
  assign wdata = {sc_q, state_q};
  assign step_cnt = sc_q;
`else
  assign wdata = state_q;
`endif

  assign step_full = lfsr_step(MAX_W'(state_q), MAX_W'(TAPS), LFSR_W);
  assign stepped = step_full[LFSR_W-1:0];
  assign slot_ok = (32'(slot) < SLOTS);
  assign do_rest = restore && slot_ok;

  prng_slot_bank #(
    .SLOTS(SLOTS),
    .DW(DW),
    .SW(SW),
    .RST_VAL(DW'(RESET_SEED))
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .we(save && slot_ok),
    .widx(slot),
    .wdata(wdata),
    .ridx(slot),
    .rdata(rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fsm_d = fsm_q;
`ifdef PRNG_STEP_CNT_EN
    sc_d = sc_q;
`endif
    if (seed_ld) begin
      state_d = seed;
      fsm_d = IDLE;
      cnt_d = '0;
`ifdef PRNG_STEP_CNT_EN
      sc_d = '0;
`endif
    end else if (do_rest) begin
      state_d = rdata[LFSR_W-1:0];
      fsm_d = IDLE;
      cnt_d = '0;
`ifdef PRNG_STEP_CNT_EN
      sc_d = rdata[DW-1:LFSR_W];
`endif
    end else if (fsm_q == SKIP || next) begin
      state_d = stepped;
`ifdef PRNG_STEP_CNT_EN
      sc_d = sc_q + 32'd1;
`endif
      if (fsm_q == SKIP) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) fsm_d = IDLE;
      end
    end
    // A skip request is only honoured from IDLE and applies after any load.
    if (fsm_q == IDLE && skip_start && skip_cnt != '0) begin
      fsm_d = SKIP;
      cnt_d = skip_cnt;
    end
    busy_d = (fsm_d == SKIP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_SEED;
      cnt_q <= '0;
      fsm_q <= IDLE;
      busy_q <= 1'b0;
`ifdef PRNG_STEP_CNT_EN
      sc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fsm_q <= fsm_d;
      busy_q <= busy_d;
`ifdef PRNG_STEP_CNT_EN
      sc_q <= sc_d;
`endif
    end
  end

  assign busy = busy_q;
  assign out = state_q[OUT_W-1:0];

endmodule
